// File: rtl/phys_reg_free_list.sv
// phys_reg_free_list: circular FIFO of free physical register indices.
// The head feeds rename, the tail takes registers freed at ROB commit, and a
// committed (architectural) head lets a flush hand back every speculatively
// allocated register in a single cycle.
// Optional feature macro: FREE_LIST_DUP_CHECK_EN adds a free bitmap that
// drops double-frees and reports them on dup_err.
// Pointers carry one extra wrap bit; DEPTH must be a power of two so the
// natural PTR_W-bit rollover is the required modulo-2*DEPTH arithmetic.
module phys_reg_free_list #(
  parameter  int PHYS_REG_BITS = 6,
  parameter  int NUM_PHYS      = 64,
  parameter  int ARCH_REGS     = 32,
  localparam int DEPTH         = NUM_PHYS - ARCH_REGS,
  localparam int PTR_W         = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dequeue,
  output logic [PHYS_REG_BITS-1:0] phys_reg,
  output logic                     is_free_list_empty,
  input  logic                     enqueue,
  input  logic [PHYS_REG_BITS-1:0] enqueue_preg,
  input  logic                     commit_alloc,
  input  logic                     flush,
  output logic [PTR_W-1:0]         free_count,
  output logic                     overflow
`ifdef FREE_LIST_DUP_CHECK_EN
  ,output logic                    dup_err
`endif
);

  localparam int IDX_W = PTR_W - 1;

  logic [PHYS_REG_BITS-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]         head_q, head_d;
  logic [PTR_W-1:0]         tail_q, tail_d;
  logic [PTR_W-1:0]         arch_head_q, arch_head_d;
  logic                     overflow_q, overflow_d;

  logic empty_s, full_s, deq_acc_s, enq_valid_s, enq_acc_s, dup_s;

  // Occupancy flags straight from the registered pointers.
  always_comb begin
    empty_s = (head_q == tail_q);
    full_s  = (head_q[PTR_W-1] != tail_q[PTR_W-1]) &&
              (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]);
  end

  assign phys_reg           = mem_q[head_q[IDX_W-1:0]];
  assign is_free_list_empty = empty_s;
  assign free_count         = tail_q - head_q;
  assign overflow           = overflow_q;

  // Accept/drop decisions and pointer next-state; flush wins over dequeue.
  always_comb begin
    deq_acc_s   = dequeue && !empty_s && !flush;
    enq_valid_s = enqueue && (enqueue_preg != {PHYS_REG_BITS{1'b0}}) && !dup_s;
    // A full list still takes a free when this cycle's dequeue makes room.
    enq_acc_s   = enq_valid_s && (!full_s || deq_acc_s);
    overflow_d  = overflow_q | (enq_valid_s && full_s && !deq_acc_s);

    if (enq_acc_s) begin
      tail_d = tail_q + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      tail_d = tail_q;
    end

    // Commit can only retire registers that rename has actually taken.
    if (commit_alloc && (arch_head_q != head_q)) begin
      arch_head_d = arch_head_q + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      arch_head_d = arch_head_q;
    end

    if (flush) begin
      head_d = arch_head_d;
    end else if (deq_acc_s) begin
      head_d = head_q + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      head_d = head_q;
    end
  end

  // FIFO storage and pointers; reset preloads the non-architectural registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= PHYS_REG_BITS'(ARCH_REGS + i);
      end
      head_q      <= {PTR_W{1'b0}};
      arch_head_q <= {PTR_W{1'b0}};
      tail_q      <= PTR_W'(DEPTH);
      overflow_q  <= 1'b0;
    end else begin
      if (enq_acc_s) begin
        mem_q[tail_q[IDX_W-1:0]] <= enqueue_preg;
      end
      head_q      <= head_d;
      arch_head_q <= arch_head_d;
      tail_q      <= tail_d;
      overflow_q  <= overflow_d;
    end
  end

`ifdef FREE_LIST_DUP_CHECK_EN
  logic [NUM_PHYS-1:0] free_q, free_d;
  logic                dup_err_q;
  logic [PTR_W-1:0]    span_s, walk_s;

  assign dup_s   = enqueue && (enqueue_preg != {PHYS_REG_BITS{1'b0}}) && free_q[enqueue_preg];
  assign dup_err = dup_err_q;

  // Free bitmap next-state: allocate clears, reclaim sets, flush re-marks
  // everything between the committed head and the speculative head.
  always_comb begin
    free_d = free_q;
    span_s = head_q - arch_head_d;
    walk_s = arch_head_d;
    if (deq_acc_s) begin
      free_d[phys_reg] = 1'b0;
    end else begin
      free_d = free_d;
    end
    if (enq_acc_s) begin
      free_d[enqueue_preg] = 1'b1;
    end else begin
      free_d = free_d;
    end
    if (flush) begin
      for (int j = 0; j < DEPTH; j++) begin
        walk_s = arch_head_d + PTR_W'(j);
        if (PTR_W'(j) < span_s) begin
          free_d[mem_q[walk_s[IDX_W-1:0]]] = 1'b1;
        end else begin
          free_d = free_d;
        end
      end
    end else begin
      free_d = free_d;
    end
  end

  // Bitmap state and the one-cycle duplicate-free pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      free_q    <= {{DEPTH{1'b1}}, {ARCH_REGS{1'b0}}};
      dup_err_q <= 1'b0;
    end else begin
      free_q    <= free_d;
      dup_err_q <= dup_s;
    end
  end
`else
  assign dup_s = 1'b0;
`endif

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed bench for phys_reg_free_list. A queue-based reference (free list
// plus speculatively allocated list) predicts each cycle; predictions go to a
// scoreboard queue when a step is driven and are checked after the edge.
module tb_phys_reg_free_list;

  logic       clk;
  logic       rst;
  logic       dequeue;
  logic [5:0] phys_reg;
  logic       is_free_list_empty;
  logic       enqueue;
  logic [5:0] enqueue_preg;
  logic       commit_alloc;
  logic       flush;
  logic [5:0] free_count;
  logic       overflow;
`ifdef FREE_LIST_DUP_CHECK_EN
  logic       dup_err;
`endif

  phys_reg_free_list dut (
    .clk                (clk),
    .rst                (rst),
    .dequeue            (dequeue),
    .phys_reg           (phys_reg),
    .is_free_list_empty (is_free_list_empty),
    .enqueue            (enqueue),
    .enqueue_preg       (enqueue_preg),
    .commit_alloc       (commit_alloc),
    .flush              (flush),
    .free_count         (free_count),
    .overflow           (overflow)
`ifdef FREE_LIST_DUP_CHECK_EN
    ,.dup_err           (dup_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] pr;
    logic       chk_pr;
    int         cnt;
    logic       emp;
    logic       ovf;
    logic       dup;
  } exp_t;

  exp_t sb_q[$];
  int   fl_q[$];   // free list, head first
  int   al_q[$];   // allocated but not yet committed, oldest first
  logic m_ovf;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic in_fl(input int p);
    foreach (fl_q[k]) if (fl_q[k] == p) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    fl_q.delete();
    al_q.delete();
    for (int i = 0; i < 32; i++) fl_q.push_back(32 + i);
    m_ovf = 1'b0;
  endtask

  task automatic check_state(input string tag, input exp_t ex);
    if (ex.chk_pr) chk({tag, ".phys_reg"}, {26'd0, phys_reg}, {26'd0, ex.pr});
    chk({tag, ".free_count"}, {26'd0, free_count}, ex.cnt);
    chk({tag, ".empty"}, {31'd0, is_free_list_empty}, {31'd0, ex.emp});
    chk({tag, ".overflow"}, {31'd0, overflow}, {31'd0, ex.ovf});
`ifdef FREE_LIST_DUP_CHECK_EN
    chk({tag, ".dup_err"}, {31'd0, dup_err}, {31'd0, ex.dup});
`endif
  endtask

  function automatic exp_t model_view(input logic dupv);
    exp_t ex;
    ex.cnt    = fl_q.size();
    ex.emp    = (fl_q.size() == 0);
    ex.chk_pr = !ex.emp;
    ex.pr     = ex.emp ? 6'd0 : 6'(fl_q[0]);
    ex.ovf    = m_ovf;
    ex.dup    = dupv;
    return ex;
  endfunction

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b0; dequeue = 1'b0; enqueue = 1'b0; enqueue_preg = 6'd0;
    commit_alloc = 1'b0; flush = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    check_state(tag, model_view(1'b0));
  endtask

  task automatic step(input logic d, input logic e, input logic [5:0] p,
                      input logic c, input logic f, input string tag);
    exp_t ex;
    int   sz, tmp;
    logic deq_acc, enq_v, isdup;
    @(negedge clk);
    dequeue = d; enqueue = e; enqueue_preg = p; commit_alloc = c; flush = f;
    sz      = fl_q.size();
    deq_acc = d && (sz != 0) && !f;
    isdup   = 1'b0;
`ifdef FREE_LIST_DUP_CHECK_EN
    isdup   = e && (p != 6'd0) && in_fl(int'(p));
`endif
    enq_v   = e && (p != 6'd0) && !isdup;
    if (c && al_q.size() > 0) tmp = al_q.pop_front();
    if (deq_acc) begin
      tmp = fl_q.pop_front();
      al_q.push_back(tmp);
    end
    if (enq_v) begin
      if (sz < 32 || deq_acc) fl_q.push_back(int'(p));
      else m_ovf = 1'b1;
    end
    if (f) begin
      fl_q = {al_q, fl_q};
      al_q.delete();
    end
    sb_q.push_back(model_view(isdup));
    @(posedge clk);
    #1;
    ex = sb_q.pop_front();
    check_state(tag, ex);
    dequeue = 1'b0; enqueue = 1'b0; enqueue_preg = 6'd0;
    commit_alloc = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst = 1'b0; dequeue = 1'b0; enqueue = 1'b0; enqueue_preg = 6'd0;
    commit_alloc = 1'b0; flush = 1'b0;

    // Reset state
    do_reset("reset");

    // Drain the list completely, then one dequeue too many
    for (int i = 0; i < 32; i++) step(1'b1, 1'b0, 6'd0, 1'b0, 1'b0, "drain");
    step(1'b1, 1'b0, 6'd0, 1'b0, 1'b0, "deq_empty");

    // Enqueue into an empty list with a same-cycle dequeue (no bypass)
    step(1'b1, 1'b1, 6'd40, 1'b0, 1'b0, "enq_empty");

    // Retire every allocation, plus one commit with nothing to retire
    for (int i = 0; i < 32; i++) step(1'b0, 1'b0, 6'd0, 1'b1, 1'b0, "commit");
    step(1'b0, 1'b0, 6'd0, 1'b1, 1'b0, "commit_idle");

    // Fill back to full with distinct registers
    for (int i = 1; i < 32; i++) step(1'b0, 1'b1, 6'(i), 1'b0, 1'b0, "fill");

    // Full: dropped enqueue sets overflow; with a dequeue both proceed
    step(1'b0, 1'b1, 6'd45, 1'b0, 1'b0, "full_drop");
    step(1'b1, 1'b1, 6'd46, 1'b0, 1'b0, "full_deq");
    step(1'b0, 1'b0, 6'd0, 1'b1, 1'b0, "commit_40");

    // Freeing register zero is ignored
    step(1'b1, 1'b0, 6'd0, 1'b0, 1'b0, "pre_zero");
    step(1'b0, 1'b1, 6'd0, 1'b0, 1'b0, "enq_zero");

    // Flush after 5 allocations and 2 commits
    do_reset("reset2");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 6'd0, 1'b0, 1'b0, "f_deq");
    step(1'b0, 1'b0, 6'd0, 1'b1, 1'b0, "f_commit");
    step(1'b0, 1'b0, 6'd0, 1'b1, 1'b0, "f_commit");
    step(1'b1, 1'b0, 6'd0, 1'b0, 1'b1, "flush");
    chk("flush.pr34", {26'd0, phys_reg}, 32'd34);
    chk("flush.cnt30", {26'd0, free_count}, 32'd30);

    // Same sequence after the pointers have wrapped
    do_reset("reset3");
    for (int i = 0; i < 40; i++) begin
      if (al_q.size() > 0) step(1'b1, 1'b1, 6'(al_q[0]), 1'b1, 1'b0, "wrap_run");
      else step(1'b1, 1'b0, 6'd0, 1'b0, 1'b0, "wrap_run");
    end
    step(1'b0, 1'b1, 6'(al_q[0]), 1'b1, 1'b0, "wrap_drain");
    step(1'b0, 1'b0, 6'd0, 1'b1, 1'b0, "wrap_idle");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 6'd0, 1'b0, 1'b0, "wf_deq");
    step(1'b0, 1'b0, 6'd0, 1'b1, 1'b0, "wf_commit");
    step(1'b0, 1'b0, 6'd0, 1'b1, 1'b0, "wf_commit");
    step(1'b0, 1'b1, 6'd7, 1'b0, 1'b1, "wf_flush_enq");
    step(1'b1, 1'b0, 6'd0, 1'b0, 1'b0, "wf_after");

`ifdef FREE_LIST_DUP_CHECK_EN
    // Double free of a register that is still free is dropped and flagged
    do_reset("reset4");
    step(1'b1, 1'b0, 6'd0, 1'b0, 1'b0, "dup_pre");
    step(1'b0, 1'b1, 6'd33, 1'b0, 1'b0, "dup_33");
    step(1'b0, 1'b1, 6'd32, 1'b0, 1'b0, "dup_ok32");
    step(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, "dup_clear");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
